// File: rtl/saturating_narrower_pkg.sv
// Shared definitions for the saturating narrower: FSM state encoding and
// the saturation constants used when a wide result does not fit.
package saturating_narrower_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Largest positive N-bit two's complement value (0 followed by N-1 ones)
    function automatic logic [31:0] maxpos(input int unsigned n);
        return (32'd1 << (n - 1)) - 32'd1;
    endfunction

    // Most negative N-bit two's complement value (1 followed by N-1 zeros)
    function automatic logic [31:0] minneg(input int unsigned n);
        return 32'd1 << (n - 1);
    endfunction

endpackage

// File: rtl/saturating_narrower_if.sv
// Valid/ready handshake bundle for the narrower: wide signed input side
// with its per-item saturate/wrap select, and the narrowed output side.
interface saturating_narrower_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N+1:0] in_data;
    logic         sat_en;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_ovf;

    modport master (
        output in_valid, in_data, sat_en, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, sat_en, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/saturating_narrower_narrow_core.sv
// Combinational narrowing of an (N+2)-bit signed value to N bits: a fit
// test on the top three bits, then either saturation or plain truncation.
module saturating_narrower_narrow_core
    import saturating_narrower_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N+1:0] in_data,
    input  logic         sat_en,
    output logic [N-1:0] data,
    output logic         ovf
);

    localparam logic [31:0] MAX_W = maxpos(N);
    localparam logic [31:0] MIN_W = minneg(N);
    localparam logic [N-1:0] MAX_V = MAX_W[N-1:0];
    localparam logic [N-1:0] MIN_V = MIN_W[N-1:0];

    // The value fits when the two dropped bits merely repeat the new sign bit
    always_comb begin
        ovf  = !((in_data[N+1] == in_data[N]) && (in_data[N] == in_data[N-1]));
        data = in_data[N-1:0];
        if (ovf && sat_en) begin
            data = in_data[N+1] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/saturating_narrower.sv
// Narrows ALU results back to N bits behind a valid/ready handshake.
// An output register plus a one-entry skid register keep full throughput
// while in_ready stays a pure register output. Also counts overflows.
module saturating_narrower
    import saturating_narrower_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    saturating_narrower_if.slave bus,
    input  logic              clr_count,
    output logic [CNT_W-1:0]  ovf_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t         state_q;
    state_t         state_d;
    logic           in_ready_q;
    logic [N-1:0]   or_data;
    logic           or_ovf;
    logic [N-1:0]   sk_data;
    logic           sk_ovf;
    logic [N-1:0]   nar_data;
    logic           nar_ovf;
    logic           out_valid_w;
    logic           accept;
    logic           pop;
    logic           load_or;
    logic           load_sk;
    logic           move_sk;
    logic [CNT_W-1:0] cnt_q;

    saturating_narrower_narrow_core #(.N(N)) u_core (
        .in_data (bus.in_data),
        .sat_en  (bus.sat_en),
        .data    (nar_data),
        .ovf     (nar_ovf)
    );

    assign out_valid_w   = (state_q != ST_EMPTY);
    assign accept        = bus.in_valid && in_ready_q;
    assign pop           = out_valid_w && bus.out_ready;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = or_data;
    assign bus.out_ovf   = or_ovf;
    assign ovf_count     = cnt_q;

    // Next-state and register load decisions from the current occupancy
    always_comb begin
        state_d = state_q;
        load_or = 1'b0;
        load_sk = 1'b0;
        move_sk = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    load_or = 1'b1;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    load_or = 1'b1;
                end else if (accept) begin
                    load_sk = 1'b1;
                    state_d = ST_TWO;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    move_sk = 1'b1;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State, registered in_ready and the two storage entries
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
            or_data    <= '0;
            or_ovf     <= 1'b0;
            sk_data    <= '0;
            sk_ovf     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_TWO);
            if (load_or) begin
                or_data <= nar_data;
                or_ovf  <= nar_ovf;
            end else if (move_sk) begin
                or_data <= sk_data;
                or_ovf  <= sk_ovf;
            end
            if (load_sk) begin
                sk_data <= nar_data;
                sk_ovf  <= nar_ovf;
            end
        end
    end

    // Saturating count of accepted overflows; clear wins over increment
    always_ff @(posedge clk) begin
        if (reset || clr_count) begin
            cnt_q <= '0;
        end else if (accept && nar_ovf && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_saturating_narrower.sv
// Testbench for saturating_narrower: directed steps plus random traffic,
// checked against an arithmetic reference model and an expected-item queue.
module tb_saturating_narrower;

    localparam int N     = 4;
    localparam int CNT_W = 8;
    localparam int CNT_LIMIT = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [N-1:0] data;
        logic         ovf;
    } item_t;

    logic             clk;
    logic             reset;
    logic             clr_count;
    logic [CNT_W-1:0] ovf_count;

    int    assert_count = 0;
    int    fail_count   = 0;
    bit    rnd_ready    = 0;
    bit    started      = 0;
    int    model_cnt    = 0;
    item_t exp_q[$];

    saturating_narrower_if #(.N(N)) bus ();

    saturating_narrower #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .clr_count (clr_count),
        .ovf_count (ovf_count)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference narrowing done on integers: range check, clamp or modulo
    function automatic item_t refNarrow(input logic [N+1:0] d, input logic s);
        item_t r;
        int v;
        int hi;
        int lo;
        v  = int'($signed(d));
        hi = (1 << (N - 1)) - 1;
        lo = -(1 << (N - 1));
        r.ovf = (v > hi) || (v < lo);
        if (r.ovf && s) r.data = (v > hi) ? N'(hi) : N'(lo);
        else            r.data = N'(v);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one item and hold it until it is accepted (bounded wait)
    task automatic applyStimulus(input logic [N+1:0] d, input logic s);
        bit done;
        done = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.sat_en   = s;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.in_ready === 1'b1) done = 1;
            @(posedge clk); #1;
            if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
        end
        checkOutput("accept_in_time", {31'd0, done}, 32'd1);
    endtask

    task automatic nextCycle();
        @(posedge clk); #1;
    endtask

    // Scoreboard: sampled on the falling edge, away from state updates
    initial begin
        forever begin
            item_t e;
            @(negedge clk);
            if (reset === 1'b1) begin
                exp_q.delete();
                model_cnt = 0;
                started   = 1;
            end else if (started) begin
                checkOutput("sb_ovf_count", {24'd0, ovf_count}, model_cnt);
                if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                    checkOutput("sb_pop_has_item", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        checkOutput("sb_data", {28'd0, bus.out_data}, {28'd0, e.data});
                        checkOutput("sb_ovf", {31'd0, bus.out_ovf}, {31'd0, e.ovf});
                    end
                end
                if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                    e = refNarrow(bus.in_data, bus.sat_en);
                    exp_q.push_back(e);
                    if (e.ovf && model_cnt < CNT_LIMIT) model_cnt++;
                end
                if (clr_count === 1'b1) model_cnt = 0;
            end
        end
    end

    // Watchdog so a stuck design still ends the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        logic [N+1:0] d;

        reset         = 1'b1;
        clr_count     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.sat_en    = 1'b1;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) nextCycle();
        checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("rst_out_data", {28'd0, bus.out_data}, 32'd0);
        checkOutput("rst_out_ovf", {31'd0, bus.out_ovf}, 32'd0);
        checkOutput("rst_count", {24'd0, ovf_count}, 32'd0);
        reset = 1'b0;
        nextCycle();
        checkOutput("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Step 1: saturating, boundary values back to back
        $display("[TB] step 1: saturation boundaries");
        applyStimulus(6'b000111, 1'b1);
        checkOutput("s1_valid0", {31'd0, bus.out_valid}, 32'd1);
        checkOutput("s1_data0", {28'd0, bus.out_data}, 32'h7);
        checkOutput("s1_ovf0", {31'd0, bus.out_ovf}, 32'd0);
        applyStimulus(6'b001000, 1'b1);
        checkOutput("s1_data1", {28'd0, bus.out_data}, 32'h7);
        checkOutput("s1_ovf1", {31'd0, bus.out_ovf}, 32'd1);
        applyStimulus(6'b111000, 1'b1);
        checkOutput("s1_data2", {28'd0, bus.out_data}, 32'h8);
        checkOutput("s1_ovf2", {31'd0, bus.out_ovf}, 32'd0);
        applyStimulus(6'b110111, 1'b1);
        checkOutput("s1_data3", {28'd0, bus.out_data}, 32'h8);
        checkOutput("s1_ovf3", {31'd0, bus.out_ovf}, 32'd1);
        checkOutput("s1_count", {24'd0, ovf_count}, 32'd2);

        // Step 2: wrapping, with sat_en flipped after each accept
        $display("[TB] step 2: wrap mode");
        applyStimulus(6'b001000, 1'b0);
        bus.in_valid = 1'b0; bus.sat_en = 1'b1; bus.out_ready = 1'b0;
        repeat (2) begin
            nextCycle();
            checkOutput("s2_data0", {28'd0, bus.out_data}, 32'h8);
            checkOutput("s2_ovf0", {31'd0, bus.out_ovf}, 32'd1);
        end
        bus.out_ready = 1'b1;
        nextCycle();
        applyStimulus(6'b110111, 1'b0);
        bus.in_valid = 1'b0; bus.sat_en = 1'b1; bus.out_ready = 1'b0;
        repeat (2) begin
            nextCycle();
            checkOutput("s2_data1", {28'd0, bus.out_data}, 32'h7);
            checkOutput("s2_ovf1", {31'd0, bus.out_ovf}, 32'd1);
        end
        bus.out_ready = 1'b1;
        nextCycle();
        checkOutput("s2_count", {24'd0, ovf_count}, 32'd4);

        // Step 3: backpressure fills both entries and stalls the source
        $display("[TB] step 3: backpressure");
        bus.out_ready = 1'b0;
        applyStimulus(6'b000001, 1'b1);
        checkOutput("s3_a_data", {28'd0, bus.out_data}, 32'h1);
        applyStimulus(6'b000010, 1'b1);
        checkOutput("s3_ready_drop", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b1; bus.in_data = 6'b000011;
        repeat (3) begin
            nextCycle();
            checkOutput("s3_stall_ready", {31'd0, bus.in_ready}, 32'd0);
            checkOutput("s3_stall_valid", {31'd0, bus.out_valid}, 32'd1);
            checkOutput("s3_stall_data", {28'd0, bus.out_data}, 32'h1);
        end
        bus.out_ready = 1'b1;
        nextCycle();
        checkOutput("s3_b_data", {28'd0, bus.out_data}, 32'h2);
        checkOutput("s3_b_ready", {31'd0, bus.in_ready}, 32'd1);
        nextCycle();
        checkOutput("s3_c_data", {28'd0, bus.out_data}, 32'h3);
        bus.in_valid = 1'b0;
        nextCycle();
        checkOutput("s3_drained", {31'd0, bus.out_valid}, 32'd0);

        // Step 4: counter saturation and clear priority
        $display("[TB] step 4: counter saturation");
        for (int i = 0; i < 260; i++) begin
            d = 6'($urandom_range(8, 55));
            applyStimulus(d, 1'($urandom_range(0, 1)));
        end
        checkOutput("s4_count_sat", {24'd0, ovf_count}, 32'd255);
        clr_count = 1'b1;
        applyStimulus(6'b010000, 1'b1);
        clr_count = 1'b0;
        checkOutput("s4_count_clr", {24'd0, ovf_count}, 32'd0);
        bus.in_valid = 1'b0;
        repeat (2) nextCycle();

        // Step 5: reset while both entries are full
        $display("[TB] step 5: reset in full state");
        bus.out_ready = 1'b0;
        applyStimulus(6'($urandom_range(0, 63)), 1'b1);
        applyStimulus(6'($urandom_range(0, 63)), 1'b0);
        checkOutput("s5_full", {31'd0, bus.in_ready}, 32'd0);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        nextCycle();
        checkOutput("s5_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("s5_out_data", {28'd0, bus.out_data}, 32'd0);
        checkOutput("s5_count", {24'd0, ovf_count}, 32'd0);
        checkOutput("s5_in_ready_rst", {31'd0, bus.in_ready}, 32'd0);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        nextCycle();
        checkOutput("s5_in_ready", {31'd0, bus.in_ready}, 32'd1);
        repeat (3) begin
            checkOutput("s5_no_stale", {31'd0, bus.out_valid}, 32'd0);
            nextCycle();
        end

        // Step 6: random data, random sat_en, random backpressure
        $display("[TB] step 6: random traffic");
        rnd_ready = 1;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                nextCycle();
            end
        end
        rnd_ready = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && bus.out_valid === 1'b1; i++) nextCycle();
        nextCycle();
        checkOutput("final_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("final_queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
